// File: rtl/fp_to_int_if.sv
// Request/result bundle between an FP producer and the float-to-integer converter.
// The master drives the operand and request; the slave returns status and the result.
interface fp_to_int_if #(
  parameter int unsigned OUT_W = 32
);
  logic [31:0]      a;
  logic             data_valid;
  logic             busy;
  logic [OUT_W-1:0] result;
  logic             result_valid;
  logic             error;
  logic             overflow;

  modport master (
    output a, data_valid,
    input  busy, result, result_valid, error, overflow
  );

  modport slave (
    input  a, data_valid,
    output busy, result, result_valid, error, overflow
  );
endinterface

// File: rtl/fp_to_int_converter.sv
// Five-state converter from IEEE-754 single precision to a saturating signed integer,
// with optional round-to-nearest-even.
module fp_to_int_converter #(
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned RND_MODE = 1
) (
  input logic        clk,
  input logic        rst_n,
  fp_to_int_if.slave bus
);

  localparam int unsigned       MW     = OUT_W + 1;
  localparam logic signed [9:0] OutWS  = 10'(OUT_W);
  localparam logic [OUT_W:0]    LimPos = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0]    LimNeg = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]  SatPos = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  SatNeg = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StShift, StRound, StCheck, StFinish} state_e;

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [7:0]       exp_q, exp_d;
  logic [22:0]      man_q, man_d;
  logic             nan_q, nan_d, inf_q, inf_d, zero_q, zero_d, big_q, big_d;
  logic             guard_q, guard_d, rnd_q, rnd_d, sticky_q, sticky_d;
  logic [OUT_W:0]   mag_q, mag_d;
  logic [OUT_W-1:0] res_q, res_d, result_q, result_d;
  logic             err_q, err_d, ovf_q, ovf_d;
  logic             error_q, error_d, overflow_q, overflow_d, valid_q, valid_d;

  logic signed [9:0] e;
  logic [23:0]       m;
  logic [49:0]       shifted;
  logic [5:0]        rsh, lsh;
  logic              inc, too_big;

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    man_d      = man_q;
    nan_d      = nan_q;
    inf_d      = inf_q;
    zero_d     = zero_q;
    big_d      = big_q;
    guard_d    = guard_q;
    rnd_d      = rnd_q;
    sticky_d   = sticky_q;
    mag_d      = mag_q;
    res_d      = res_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    error_d    = error_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    m          = {1'b1, man_q};
    e          = $signed({2'b00, exp_q}) - 10'sd127;
    rsh        = '0;
    lsh        = '0;
    shifted    = '0;
    inc        = 1'b0;
    too_big    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.data_valid) begin
          sign_d  = bus.a[31];
          exp_d   = bus.a[30:23];
          man_d   = bus.a[22:0];
          nan_d   = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] != '0);
          inf_d   = (bus.a[30:23] == 8'hFF) && (bus.a[22:0] == '0);
          zero_d  = (bus.a[30:23] == 8'h00);
          state_d = StShift;
        end
      end
      StShift: begin
        big_d = (e >= OutWS);
        if (e < 10'sd23) begin
          // Mantissa sits above a 26-bit fraction field; beyond 25 places only sticky survives.
          rsh      = (e < -10'sd2) ? 6'd25 : 6'(10'sd23 - e);
          shifted  = {m, 26'b0} >> rsh;
          mag_d    = MW'(shifted[49:26]);
          guard_d  = shifted[25];
          rnd_d    = shifted[24];
          sticky_d = |shifted[23:0];
        end else begin
          lsh      = (e > 10'sd62) ? 6'd40 : 6'(e - 10'sd23);
          mag_d    = MW'(m) << lsh;
          guard_d  = 1'b0;
          rnd_d    = 1'b0;
          sticky_d = 1'b0;
        end
        state_d = StRound;
      end
      StRound: begin
        inc     = (RND_MODE != 0) && guard_q && (rnd_q || sticky_q || mag_q[0]);
        mag_d   = mag_q + MW'(inc);
        state_d = StCheck;
      end
      StCheck: begin
        err_d   = 1'b0;
        ovf_d   = 1'b0;
        too_big = big_q || (mag_q > (sign_q ? LimNeg : LimPos));
        if (nan_q) begin
          res_d = '0;
          err_d = 1'b1;
        end else if (inf_q) begin
          res_d = sign_q ? SatNeg : SatPos;
          ovf_d = 1'b1;
        end else if (zero_q) begin
          res_d = '0;
        end else if (too_big) begin
          res_d = sign_q ? SatNeg : SatPos;
          ovf_d = 1'b1;
        end else begin
          res_d = sign_q ? -mag_q[OUT_W-1:0] : mag_q[OUT_W-1:0];
        end
        state_d = StFinish;
      end
      StFinish: begin
        result_d   = res_q;
        error_d    = err_q;
        overflow_d = ovf_q;
        valid_d    = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      man_q      <= '0;
      nan_q      <= 1'b0;
      inf_q      <= 1'b0;
      zero_q     <= 1'b0;
      big_q      <= 1'b0;
      guard_q    <= 1'b0;
      rnd_q      <= 1'b0;
      sticky_q   <= 1'b0;
      mag_q      <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      man_q      <= man_d;
      nan_q      <= nan_d;
      inf_q      <= inf_d;
      zero_q     <= zero_d;
      big_q      <= big_d;
      guard_q    <= guard_d;
      rnd_q      <= rnd_d;
      sticky_q   <= sticky_d;
      mag_q      <= mag_d;
      res_q      <= res_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.busy         = (state_q != StIdle);
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.error        = error_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Bench for fp_to_int_converter: three instances (32-bit RNE, 32-bit truncate, 16-bit RNE)
// share one request stream and are checked against an arithmetic reference model.
module tb_fp_to_int_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0;
  logic        dv = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fp_to_int_if #(.OUT_W(32)) if_n32 ();
  fp_to_int_if #(.OUT_W(32)) if_t32 ();
  fp_to_int_if #(.OUT_W(16)) if_n16 ();

  assign if_n32.a = a;
  assign if_t32.a = a;
  assign if_n16.a = a;
  assign if_n32.data_valid = dv;
  assign if_t32.data_valid = dv;
  assign if_n16.data_valid = dv;

  fp_to_int_converter #(.OUT_W(32), .RND_MODE(1)) u_n32 (.clk(clk), .rst_n(rst_n), .bus(if_n32));
  fp_to_int_converter #(.OUT_W(32), .RND_MODE(0)) u_t32 (.clk(clk), .rst_n(rst_n), .bus(if_t32));
  fp_to_int_converter #(.OUT_W(16), .RND_MODE(1)) u_n16 (.clk(clk), .rst_n(rst_n), .bus(if_n16));

  logic [31:0] obs_res [3];
  logic        obs_err [3];
  logic        obs_ovf [3];
  logic        obs_rv  [3];
  logic        obs_busy[3];
  int          obs_lat;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] rne;
    logic [31:0] trn;
    logic        err;
    logic        ovf;
  } vec_t;

  // Returns {error, overflow, result}; result is the ow-bit value sign-extended to 32 bits.
  function automatic logic [33:0] model(input logic [31:0] x, input int ow, input bit rne);
    int          ex, e, sh;
    longint      m, ip, rem, half, lim;
    logic [31:0] r;
    ex = int'(x[30:23]);
    e  = ex - 127;
    m  = longint'({1'b1, x[22:0]});
    ip = 0;
    if (ex == 255) begin
      if (x[22:0] != 23'h0) return {2'b10, 32'h0};
      ip = 64'sd1 << 40;
    end else if (ex == 0) begin
      return {2'b00, 32'h0};
    end else if (e >= 40) begin
      ip = 64'sd1 << 40;
    end else if (e >= 23) begin
      ip = m << (e - 23);
    end else if (e > -40) begin
      sh   = 23 - e;
      ip   = m >> sh;
      rem  = m - (ip << sh);
      half = 64'sd1 << (sh - 1);
      if (rne && (rem > half || (rem == half && ip[0]))) ip = ip + 1;
    end
    lim = (64'sd1 << (ow - 1)) - (x[31] ? 64'sd0 : 64'sd1);
    if (ip > lim) begin
      r = x[31] ? 32'(-(64'sd1 << (ow - 1))) : 32'(lim);
      return {2'b01, r};
    end
    r = 32'(x[31] ? -ip : ip);
    return {2'b00, r};
  endfunction

  task automatic capture();
    obs_res[0]  = if_n32.result;
    obs_res[1]  = if_t32.result;
    obs_res[2]  = {16'h0, if_n16.result};
    obs_err[0]  = if_n32.error;
    obs_err[1]  = if_t32.error;
    obs_err[2]  = if_n16.error;
    obs_ovf[0]  = if_n32.overflow;
    obs_ovf[1]  = if_t32.overflow;
    obs_ovf[2]  = if_n16.overflow;
    obs_rv[0]   = if_n32.result_valid;
    obs_rv[1]   = if_t32.result_valid;
    obs_rv[2]   = if_n16.result_valid;
    obs_busy[0] = if_n32.busy;
    obs_busy[1] = if_t32.busy;
    obs_busy[2] = if_n16.busy;
  endtask

  // One request; a is scrambled after the sampling edge. obs_lat=0 means no result arrived.
  task automatic send(input logic [31:0] x);
    @(negedge clk);
    a  = x;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    a  = $urandom;
    obs_lat = 0;
    for (int c = 1; c <= 10; c++) begin
      if (if_n32.result_valid) begin
        obs_lat = c;
        break;
      end
      @(negedge clk);
    end
    capture();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      capture();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs_res[k] !== 32'h0 || obs_err[k] !== 1'b0 || obs_ovf[k] !== 1'b0 ||
            obs_rv[k] !== 1'b0 || obs_busy[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset dut%0d pass%0d got res=%h err=%b ovf=%b rv=%b busy=%b expected all 0",
                   k, pass, obs_res[k], obs_err[k], obs_ovf[k], obs_rv[k], obs_busy[k]);
        end
      end
      rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_directed();
    vec_t        v [15];
    logic [33:0] ex16;
    v = '{'{32'h3FC00000, 32'h00000002, 32'h00000001, 1'b0, 1'b0},
          '{32'h40200000, 32'h00000002, 32'h00000002, 1'b0, 1'b0},
          '{32'hC0600000, 32'hFFFFFFFC, 32'hFFFFFFFD, 1'b0, 1'b0},
          '{32'h3F7FFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0},
          '{32'h4F000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1},
          '{32'hCF000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0},
          '{32'h7F800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1},
          '{32'hFF800000, 32'h80000000, 32'h80000000, 1'b0, 1'b1},
          '{32'h7FC00000, 32'h00000000, 32'h00000000, 1'b1, 1'b0},
          '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0},
          '{32'h3F000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0},
          '{32'h3F400000, 32'h00000001, 32'h00000000, 1'b0, 1'b0},
          '{32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0},
          '{32'hBF000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0},
          '{32'h4EFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80, 1'b0, 1'b0}};
    for (int i = 0; i < 15; i++) begin
      send(v[i].x);
      ex16 = model(v[i].x, 16, 1'b1);
      n_checks++;
      if (obs_lat != 5) begin
        n_fail++;
        $display("FAIL latency a=%h got %0d expected 5", v[i].x, obs_lat);
      end
      n_checks++;
      if (obs_res[0] !== v[i].rne || obs_err[0] !== v[i].err || obs_ovf[0] !== v[i].ovf) begin
        n_fail++;
        $display("FAIL directed_rne a=%h got res=%h err=%b ovf=%b expected res=%h err=%b ovf=%b",
                 v[i].x, obs_res[0], obs_err[0], obs_ovf[0], v[i].rne, v[i].err, v[i].ovf);
      end
      n_checks++;
      if (obs_res[1] !== v[i].trn || obs_err[1] !== v[i].err || obs_ovf[1] !== v[i].ovf) begin
        n_fail++;
        $display("FAIL directed_trunc a=%h got res=%h err=%b ovf=%b expected res=%h err=%b ovf=%b",
                 v[i].x, obs_res[1], obs_err[1], obs_ovf[1], v[i].trn, v[i].err, v[i].ovf);
      end
      n_checks++;
      if (obs_res[2][15:0] !== ex16[15:0] || obs_err[2] !== ex16[33] || obs_ovf[2] !== ex16[32]) begin
        n_fail++;
        $display("FAIL directed_w16 a=%h got res=%h err=%b ovf=%b expected res=%h err=%b ovf=%b",
                 v[i].x, obs_res[2][15:0], obs_err[2], obs_ovf[2], ex16[15:0], ex16[33], ex16[32]);
      end
    end
  endtask

  task automatic test_range16();
    logic [31:0] xs [3];
    logic [15:0] er [3];
    logic        eo [3];
    xs = '{32'h46FFFF00, 32'hC7000000, 32'h47000000};
    er = '{16'h7FFF, 16'h8000, 16'h7FFF};
    eo = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send(xs[i]);
      n_checks++;
      if (obs_res[2][15:0] !== er[i] || obs_ovf[2] !== eo[i] || obs_err[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL range16 a=%h got res=%h ovf=%b err=%b expected res=%h ovf=%b err=0",
                 xs[i], obs_res[2][15:0], obs_ovf[2], obs_err[2], er[i], eo[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, mask;
    logic [33:0] ex;
    int          mode, ev, sh;
    for (int n = 0; n < 200; n++) begin
      mode = $urandom_range(0, 3);
      x    = $urandom;
      if (mode == 1) x[30:23] = 8'($urandom_range(100, 160));
      if (mode == 2) begin
        // Exact halfway values exercise the tie-to-even path.
        ev = $urandom_range(0, 22);
        sh = 23 - ev;
        x[30:23] = 8'(ev + 127);
        x[22:0]  = (x[22:0] & ~23'((1 << sh) - 1)) | 23'(1 << (sh - 1));
      end
      if (mode == 3) x[30:23] = 8'($urandom_range(141, 159));
      send(x);
      for (int k = 0; k < 3; k++) begin
        ex   = model(x, (k == 2) ? 16 : 32, k != 1);
        mask = (k == 2) ? 32'h0000FFFF : 32'hFFFFFFFF;
        n_checks++;
        if ((obs_res[k] & mask) !== (ex[31:0] & mask) || obs_err[k] !== ex[33] ||
            obs_ovf[k] !== ex[32] || obs_lat != 5) begin
          n_fail++;
          $display("FAIL random dut%0d a=%h got res=%h err=%b ovf=%b lat=%0d expected res=%h err=%b ovf=%b lat=5",
                   k, x, obs_res[k] & mask, obs_err[k], obs_ovf[k], obs_lat,
                   ex[31:0] & mask, ex[33], ex[32]);
        end
      end
    end
  endtask

  task automatic test_handshake();
    int          pulses;
    logic [31:0] first;
    @(negedge clk);
    a  = 32'h41200000;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (if_n32.busy !== 1'b1 || if_n32.result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_window cycle%0d got busy=%b rv=%b expected busy=1 rv=0",
                 c, if_n32.busy, if_n32.result_valid);
      end
      @(negedge clk);
    end
    n_checks++;
    if (if_n32.result_valid !== 1'b1 || if_n32.busy !== 1'b0 || if_n32.result !== 32'd10) begin
      n_fail++;
      $display("FAIL latency5 got rv=%b busy=%b res=%h expected rv=1 busy=0 res=0000000a",
               if_n32.result_valid, if_n32.busy, if_n32.result);
    end
    @(negedge clk);
    n_checks++;
    if (if_n32.result_valid !== 1'b0 || if_n32.result !== 32'd10) begin
      n_fail++;
      $display("FAIL pulse_hold got rv=%b res=%h expected rv=0 res=0000000a",
               if_n32.result_valid, if_n32.result);
    end

    // Request while busy must be dropped.
    @(negedge clk);
    a  = 32'h41F00000;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    @(negedge clk);
    a  = 32'hC1A00000;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    pulses = 0;
    first  = '0;
    for (int c = 0; c < 14; c++) begin
      if (if_n32.result_valid) begin
        pulses++;
        if (pulses == 1) first = if_n32.result;
      end
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 1 || first !== 32'd30) begin
      n_fail++;
      $display("FAIL busy_ignore got pulses=%0d res=%h expected pulses=1 res=0000001e", pulses, first);
    end

    // Back-to-back: next request issued in the result_valid (first idle) cycle.
    @(negedge clk);
    a  = 32'h40400000;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    obs_lat = 0;
    for (int c = 1; c <= 10; c++) begin
      if (if_n32.result_valid) begin
        obs_lat = c;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (obs_lat != 5 || if_n32.result !== 32'd3) begin
      n_fail++;
      $display("FAIL b2b_first got lat=%0d res=%h expected lat=5 res=00000003", obs_lat, if_n32.result);
    end
    a  = 32'hC0A00000;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    obs_lat = 0;
    for (int c = 1; c <= 10; c++) begin
      if (if_n32.result_valid) begin
        obs_lat = c;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (obs_lat != 5 || if_n32.result !== 32'hFFFFFFFB) begin
      n_fail++;
      $display("FAIL b2b_second got lat=%0d res=%h expected lat=5 res=fffffffb", obs_lat, if_n32.result);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    send(32'h7F800000);
    n_checks++;
    if (obs_res[0] !== 32'h7FFFFFFF || obs_ovf[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset got res=%h ovf=%b expected res=7fffffff ovf=1", obs_res[0], obs_ovf[0]);
    end
    @(negedge clk);
    a  = 32'h40400000;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_n32.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy got busy=%b expected 1", if_n32.busy);
    end
    rst_n = 1'b0;
    #1;
    capture();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs_res[k] !== 32'h0 || obs_err[k] !== 1'b0 || obs_ovf[k] !== 1'b0 ||
          obs_rv[k] !== 1'b0 || obs_busy[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d got res=%h err=%b ovf=%b rv=%b busy=%b expected all 0",
                 k, obs_res[k], obs_err[k], obs_ovf[k], obs_rv[k], obs_busy[k]);
      end
    end
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if_n32.result_valid || if_n32.busy) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL post_reset_quiet got %0d active cycles expected 0", pulses);
    end
    send(32'h40400000);
    n_checks++;
    if (obs_lat != 5 || obs_res[0] !== 32'd3 || obs_res[1] !== 32'd3) begin
      n_fail++;
      $display("FAIL post_reset_conv got lat=%0d res=%h/%h expected lat=5 res=00000003",
               obs_lat, obs_res[0], obs_res[1]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_range16();
    test_random();
    test_handshake();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
